parking_event_monitor: RTL and testbench

PARKING_EVENT_MONITOR -- requirements
Module: parking_event_monitor

---
 rtl/parking_lot_pkg.sv | 27 ++
 rtl/parking_event_monitor_if.sv | 20 ++
 rtl/event_fifo.sv | 71 +++++++
 rtl/parking_event_monitor.sv | 96 +++++++++
 tb/tb_parking_event_monitor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/parking_lot_pkg.sv
// Shared types for the parking-lot event monitor: event encodings, the queued
// event record and the default FIFO depth.
package parking_lot_pkg;

   localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      EVT_BOARD  = 2'd0,
      EVT_ALIGHT = 2'd1,
      EVT_FLOOR  = 2'd2
   } evt_type_e;

   typedef struct packed {
      evt_type_e   etype;
      logic [15:0] plate;
      logic [2:0]  floor_num;
      logic [7:0]  fee;
      logic        plate_type;
   } evt_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {7'd0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/parking_event_monitor_if.sv
// Ready/valid event stream from the monitor to its consumer.
interface parking_event_monitor_if;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_type;
   logic [15:0] evt_plate;
   logic [2:0]  evt_floor;
   logic [7:0]  evt_fee;
   logic        evt_plate_type;

   modport master (
      output evt_valid, evt_type, evt_plate, evt_floor, evt_fee, evt_plate_type,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_type, evt_plate, evt_floor, evt_fee, evt_plate_type,
      output evt_ready
   );
endinterface

// File: rtl/event_fifo.sv
// Event FIFO with three write ports (accepted in port order, excess dropped and
// counted) and one read port; a same-cycle pop frees a slot for a push.
module event_fifo
   import parking_lot_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [2:0]               wr_en,
   input  evt_t [2:0]               wr_data,
   input  logic                     rd_ready,
   output evt_t                     rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               drop_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   evt_t             mem_q [DEPTH];
   evt_t             mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, free_slots, accepted;
   logic [1:0]       dropped;
   logic [7:0]       drop_q, drop_d;
   logic             pop;

   always_comb begin
      pop        = (count_q != '0) && rd_ready;
      free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
      mem_d      = mem_q;
      accepted   = '0;
      dropped    = '0;
      // Writes land contiguously after the tail; once free slots run out the
      // remaining (later-priority) ports are dropped.
      for (int unsigned i = 0; i < 3; i++) begin
         if (wr_en[i]) begin
            if (accepted < free_slots) begin
               mem_d[wr_ptr_q + PTR_W'(accepted)] = wr_data[i];
               accepted = accepted + CNT_W'(1);
            end else begin
               dropped = dropped + 2'd1;
            end
         end
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(accepted);
      count_d  = count_q - CNT_W'(pop) + accepted;
      drop_d   = sat_add8(drop_q, dropped);
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign drop_count = drop_q;

endmodule

// File: rtl/parking_event_monitor.sv
// Watches the elevator plate/floor inputs, turns changes into BOARD/ALIGHT/FLOOR
// events queued for a consumer, and keeps running board/alight/fee statistics.
module parking_event_monitor
   import parking_lot_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [2:0]                   current_floor,
   input  logic [15:0]                  moving,
   input  logic [7:0]                   fee,
   input  logic                         plate_type,
   parking_event_monitor_if.master      evt,
   output logic [7:0]                   board_count,
   output logic [7:0]                   alight_count,
   output logic [15:0]                  fee_total,
   output logic [7:0]                   drop_count
);
   logic        prime_q, prime_d;
   logic [15:0] prev_moving_q, prev_moving_d;
   logic [2:0]  prev_floor_q, prev_floor_d;
   logic [7:0]  board_count_q, board_count_d, alight_count_q, alight_count_d;
   logic [15:0] fee_total_q, fee_total_d;
   logic [16:0] fee_sum;
   logic        moving_chg, det_alight, det_board, det_floor;
   logic [2:0]  wr_en;
   evt_t [2:0]  wr_data;
   evt_t        head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   always_comb begin
      moving_chg = moving != prev_moving_q;
      det_alight = !prime_q && moving_chg && (prev_moving_q != '0);
      det_board  = !prime_q && moving_chg && (moving != '0);
      det_floor  = !prime_q && (current_floor != prev_floor_q);

      // Port order fixes queue order: ALIGHT, BOARD, FLOOR.
      wr_en   = {det_floor, det_board, det_alight};
      wr_data = '0;
      wr_data[0] = '{EVT_ALIGHT, prev_moving_q, current_floor, fee, plate_type};
      wr_data[1] = '{EVT_BOARD, moving, current_floor, 8'd0, plate_type};
      wr_data[2] = '{EVT_FLOOR, moving, current_floor, 8'd0, plate_type};

      fee_sum        = {1'b0, fee_total_q} + (det_alight ? {9'd0, fee} : 17'd0);
      fee_total_d    = fee_sum[16] ? '1 : fee_sum[15:0];
      board_count_d  = board_count_q + 8'(det_board);
      alight_count_d = alight_count_q + 8'(det_alight);
      prime_d        = 1'b0;
      prev_moving_d  = moving;
      prev_floor_d   = current_floor;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prime_q        <= 1'b1;
         prev_moving_q  <= '0;
         prev_floor_q   <= '0;
         board_count_q  <= '0;
         alight_count_q <= '0;
         fee_total_q    <= '0;
      end else begin
         prime_q        <= prime_d;
         prev_moving_q  <= prev_moving_d;
         prev_floor_q   <= prev_floor_d;
         board_count_q  <= board_count_d;
         alight_count_q <= alight_count_d;
         fee_total_q    <= fee_total_d;
      end
   end

   event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_ready   (evt.evt_ready),
      .rd_data    (head),
      .count      (fifo_count),
      .drop_count (drop_count)
   );

   always_comb begin
      evt.evt_valid      = fifo_count != '0;
      evt.evt_type       = evt.evt_valid ? head.etype      : 2'd0;
      evt.evt_plate      = evt.evt_valid ? head.plate      : 16'd0;
      evt.evt_floor      = evt.evt_valid ? head.floor_num  : 3'd0;
      evt.evt_fee        = evt.evt_valid ? head.fee        : 8'd0;
      evt.evt_plate_type = evt.evt_valid ? head.plate_type : 1'b0;
   end

   assign board_count  = board_count_q;
   assign alight_count = alight_count_q;
   assign fee_total    = fee_total_q;

endmodule

// File: tb/tb_parking_event_monitor.sv
// Directed bench for parking_event_monitor: a vector table for single-event
// cycles plus hand sequences for ordering, overflow, saturation and reset.
module tb_parking_event_monitor;
   import parking_lot_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  current_floor;
   logic [15:0] moving;
   logic [7:0]  fee;
   logic        plate_type;
   logic [7:0]  board_count, alight_count, drop_count;
   logic [15:0] fee_total;

   parking_event_monitor_if evt_if ();

   parking_event_monitor #(.FIFO_DEPTH(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .current_floor (current_floor),
      .moving        (moving),
      .fee           (fee),
      .plate_type    (plate_type),
      .evt           (evt_if),
      .board_count   (board_count),
      .alight_count  (alight_count),
      .fee_total     (fee_total),
      .drop_count    (drop_count)
   );

   always #5 clock = ~clock;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      logic [2:0]  flr;
      logic [15:0] mov;
      logic [7:0]  fee;
      logic        pt;
      logic        exp_v;
      logic [1:0]  exp_t;
      logic [15:0] exp_p;
      logic [2:0]  exp_f;
      logic [7:0]  exp_fee;
      logic        exp_pt;
      logic [7:0]  exp_bc;
      logic [7:0]  exp_ac;
      logic [15:0] exp_ft;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic check_evt(input string name, input logic v, input logic [1:0] t,
                            input logic [15:0] p, input logic [2:0] f,
                            input logic [7:0] fe, input logic pt);
      check({name, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
      check({name, ".type"},  32'(evt_if.evt_type), 32'(t));
      check({name, ".plate"}, 32'(evt_if.evt_plate), 32'(p));
      check({name, ".floor"}, 32'(evt_if.evt_floor), 32'(f));
      check({name, ".fee"},   32'(evt_if.evt_fee), 32'(fe));
      check({name, ".ptype"}, 32'(evt_if.evt_plate_type), 32'(pt));
   endtask

   task automatic check_cnt(input string name, input logic [7:0] bc, input logic [7:0] ac,
                            input logic [15:0] ft, input logic [7:0] dc);
      check({name, ".board_count"},  32'(board_count), 32'(bc));
      check({name, ".alight_count"}, 32'(alight_count), 32'(ac));
      check({name, ".fee_total"},    32'(fee_total), 32'(ft));
      check({name, ".drop_count"},   32'(drop_count), 32'(dc));
   endtask

   initial begin
      logic [2:0]  exp_fl [8];
      logic [15:0] prev_ft;
      logic        wrapped;

      //            flr   mov       fee    pt    v     type  plate     f     fee    pt    bc    ac    ft
      vecs[0] = '{3'd0, 16'h9423, 8'd0,  1'b1, 1'b1, 2'd0, 16'h9423, 3'd0, 8'd0,  1'b1, 8'd1, 8'd0, 16'd0};
      vecs[1] = '{3'd0, 16'h9423, 8'd0,  1'b1, 1'b0, 2'd0, 16'h0000, 3'd0, 8'd0,  1'b0, 8'd1, 8'd0, 16'd0};
      vecs[2] = '{3'd0, 16'h0000, 8'd40, 1'b1, 1'b1, 2'd1, 16'h9423, 3'd0, 8'd40, 1'b1, 8'd1, 8'd1, 16'd40};
      vecs[3] = '{3'd0, 16'h8754, 8'd0,  1'b0, 1'b1, 2'd0, 16'h8754, 3'd0, 8'd0,  1'b0, 8'd2, 8'd1, 16'd40};
      vecs[4] = '{3'd0, 16'h0000, 8'd40, 1'b0, 1'b1, 2'd1, 16'h8754, 3'd0, 8'd40, 1'b0, 8'd2, 8'd2, 16'd80};
      vecs[5] = '{3'd5, 16'h0000, 8'd0,  1'b0, 1'b1, 2'd2, 16'h0000, 3'd5, 8'd0,  1'b0, 8'd2, 8'd2, 16'd80};
      vecs[6] = '{3'd5, 16'h0000, 8'd99, 1'b0, 1'b0, 2'd0, 16'h0000, 3'd0, 8'd0,  1'b0, 8'd2, 8'd2, 16'd80};

      reset = 1'b1;
      current_floor = '0;
      moving = '0;
      fee = '0;
      plate_type = 1'b0;
      evt_if.evt_ready = 1'b1;
      step();
      check_evt("reset", 1'b0, 2'd0, 16'h0, 3'd0, 8'd0, 1'b0);
      check_cnt("reset", 8'd0, 8'd0, 16'd0, 8'd0);
      reset = 1'b0;
      step();
      check("prime.valid", 32'(evt_if.evt_valid), 32'd0);

      // Single-event cycles with the consumer always ready.
      for (int i = 0; i < 7; i++) begin
         current_floor = vecs[i].flr;
         moving        = vecs[i].mov;
         fee           = vecs[i].fee;
         plate_type    = vecs[i].pt;
         step();
         check_evt($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_t, vecs[i].exp_p,
                   vecs[i].exp_f, vecs[i].exp_fee, vecs[i].exp_pt);
         check_cnt($sformatf("vec%0d", i), vecs[i].exp_bc, vecs[i].exp_ac, vecs[i].exp_ft, 8'd0);
      end

      // Simultaneous floor + plate change: ALIGHT, BOARD, FLOOR order.
      evt_if.evt_ready = 1'b0;
      current_floor = 3'd2; moving = 16'h6755; fee = 8'd0; plate_type = 1'b1;
      step();
      check_evt("simul.setup", 1'b1, 2'd0, 16'h6755, 3'd2, 8'd0, 1'b1);
      current_floor = 3'd3; moving = 16'h3851; fee = 8'd12; plate_type = 1'b0;
      step();
      check_evt("simul.hold", 1'b1, 2'd0, 16'h6755, 3'd2, 8'd0, 1'b1);
      check_cnt("simul", 8'd4, 8'd3, 16'd92, 8'd0);
      fee = 8'd0;
      evt_if.evt_ready = 1'b1;
      check_evt("simul.e0", 1'b1, 2'd0, 16'h6755, 3'd2, 8'd0,  1'b1); step();
      check_evt("simul.e1", 1'b1, 2'd2, 16'h6755, 3'd2, 8'd0,  1'b1); step();
      check_evt("simul.e2", 1'b1, 2'd1, 16'h6755, 3'd3, 8'd12, 1'b0); step();
      check_evt("simul.e3", 1'b1, 2'd0, 16'h3851, 3'd3, 8'd0,  1'b0); step();
      check_evt("simul.e4", 1'b1, 2'd2, 16'h3851, 3'd3, 8'd0,  1'b0); step();
      check_evt("simul.empty", 1'b0, 2'd0, 16'h0, 3'd0, 8'd0, 1'b0);

      // Overflow: ten FLOOR events into an 8-deep FIFO, then a push that
      // only fits because of the same-cycle pop.
      evt_if.evt_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         current_floor = 3'((4 + i) % 8);
         step();
      end
      check("ovf.drop_count", 32'(drop_count), 32'd2);
      check_evt("ovf.head", 1'b1, 2'd2, 16'h3851, 3'd4, 8'd0, 1'b0);
      evt_if.evt_ready = 1'b1;
      current_floor = 3'd6;
      step();
      check("ovf.pop_push.drop_count", 32'(drop_count), 32'd2);
      exp_fl = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      for (int k = 0; k < 8; k++) begin
         check($sformatf("ovf.drain%0d.type", k), 32'(evt_if.evt_type), 32'd2);
         check($sformatf("ovf.drain%0d.floor", k), 32'(evt_if.evt_floor), 32'(exp_fl[k]));
         step();
      end
      check("ovf.empty", 32'(evt_if.evt_valid), 32'd0);

      // Fee saturation, count wrap and drop-count saturation.
      evt_if.evt_ready = 1'b0;
      wrapped = 1'b0;
      prev_ft = fee_total;
      for (int k = 0; k < 260; k++) begin
         moving = 16'h0000; fee = 8'd255;
         step();
         if (fee_total < prev_ft) wrapped = 1'b1;
         prev_ft = fee_total;
         moving = 16'h1111; fee = 8'd0;
         step();
      end
      check("sat.no_wrap", 32'(wrapped), 32'd0);
      check_cnt("sat", 8'd8, 8'd7, 16'hFFFF, 8'hFF);

      // Reset with events queued and a same-cycle detection.
      reset = 1'b1;
      step();
      reset = 1'b0;
      current_floor = 3'd0; moving = 16'h0000;
      step();
      for (int i = 1; i <= 5; i++) begin
         current_floor = 3'(i);
         step();
      end
      check_evt("rst.queued", 1'b1, 2'd2, 16'h0, 3'd1, 8'd0, 1'b0);
      reset = 1'b1;
      moving = 16'h2222;
      step();
      check_evt("rst.mid", 1'b0, 2'd0, 16'h0, 3'd0, 8'd0, 1'b0);
      check_cnt("rst.mid", 8'd0, 8'd0, 16'd0, 8'd0);
      reset = 1'b0;
      step();
      check("rst.prime.valid", 32'(evt_if.evt_valid), 32'd0);
      check("rst.prime.board_count", 32'(board_count), 32'd0);
      step();
      check("rst.steady.valid", 32'(evt_if.evt_valid), 32'd0);
      current_floor = 3'd6;
      step();
      check_evt("rst.after", 1'b1, 2'd2, 16'h2222, 3'd6, 8'd0, 1'b0);
      check_cnt("rst.after", 8'd0, 8'd0, 16'd0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
